// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues credit-limited memory
// requests and buffers returned words in a small queue toward ID.
module if_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [31:0]     id_instr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt;

    logic [CW:0]     inflight;
    logic [XLEN-1:0] redirect_target;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count_next;
    logic [CW-1:0]   outstanding_next;

    // Queued entries plus requests still in memory never exceed DEPTH, so every
    // response always has a free slot waiting for it.
    assign inflight        = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid  = !reset && !redirect_i && (inflight < DEPTH_W);
    assign imem_req_addr   = fetch_pc;
    assign req_fire        = imem_req_valid && imem_req_ready;
    assign redirect_target = redirect_pc_i & ~XLEN'(3);

    assign id_valid    = (count != '0) && !redirect_i;
    assign id_pc       = pc_mem[rd_ptr];
    assign id_pc_plus4 = id_pc + XLEN'(4);
    assign id_instr    = instr_mem[rd_ptr];

    assign pop  = id_valid && id_ready;
    assign push = imem_rsp_valid && !redirect_i && (drop_cnt == '0);

    always_comb begin
        count_next       = count;
        outstanding_next = outstanding;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
        if (req_fire && !imem_rsp_valid) begin
            outstanding_next = outstanding + CW'(1);
        end else if (imem_rsp_valid && !req_fire) begin
            outstanding_next = outstanding - CW'(1);
        end
    end

    // A redirect flushes the queue and marks every response still owed by
    // memory (except one landing this cycle, which is dropped directly) as stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_i) begin
                fetch_pc <= redirect_target;
                rsp_pc   <= redirect_target;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                drop_cnt <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (push) begin
                    rsp_pc <= rsp_pc + XLEN'(4);
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count_next;
                if (imem_rsp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

    // Storage is cleared on reset so the head fields read zero until filled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]    <= rsp_pc;
            instr_mem[wr_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: an in-order memory model with epochs
// feeds a scoreboard of expected {pc, instr} entries toward ID.
module tb_if_fetch_queue;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk;
    logic        reset;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;

    if_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_instr       (id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    req_t        pend[$];
    exp_t        sb[$];
    logic [31:0] got_pcs[$];
    logic [31:0] accept_addrs[$];
    logic [31:0] m_fetch_pc;
    int          cyc;
    int          epoch;
    int          lat_min;
    int          lat_max;
    int          accepted;
    int          delivered;
    int          vectors;
    int          miscompares;

    function automatic logic [31:0] memword(input logic [31:0] addr);
        return {addr[15:0], ~addr[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check, update models.
    task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic mready, input logic idr);
        req_t h;
        exp_t e;
        logic rsp;
        int   d;
        rsp = (pend.size() != 0) && (pend[0].due <= cyc);
        redirect_i     = redir;
        redirect_pc_i  = rpc;
        imem_req_ready = mready;
        id_ready       = idr;
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? memword(pend[0].addr) : 32'hDEAD_BEEF;
        #1;
        checkOutput("req_valid", 32'(imem_req_valid), 32'(!redir && (sb.size() + pend.size() < 4)));
        checkOutput("id_valid", 32'(id_valid), 32'(!redir && (sb.size() != 0)));
        if (id_valid && idr) begin
            if (sb.size() == 0) begin
                checkOutput("sb_empty", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                checkOutput("id_pc", id_pc, e.pc);
                checkOutput("id_pc_plus4", id_pc_plus4, e.pc + 32'd4);
                checkOutput("id_instr", id_instr, e.instr);
            end
            got_pcs.push_back(id_pc);
            delivered++;
        end
        if (rsp) begin
            h = pend.pop_front();
            if (!redir && (h.epoch == epoch)) begin
                e.pc    = h.addr;
                e.instr = memword(h.addr);
                sb.push_back(e);
            end
        end
        if (imem_req_valid && mready) begin
            checkOutput("req_addr", imem_req_addr, m_fetch_pc);
            d = cyc + int'($urandom_range(lat_min, lat_max));
            if ((pend.size() != 0) && (d < pend[pend.size() - 1].due)) begin
                d = pend[pend.size() - 1].due;
            end
            h.addr  = m_fetch_pc;
            h.epoch = epoch;
            h.due   = d;
            pend.push_back(h);
            accept_addrs.push_back(m_fetch_pc);
            accepted++;
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (redir) begin
            sb.delete();
            epoch++;
            m_fetch_pc = rpc & ~32'h3;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Asserts reset between clock edges, checks the immediate effect, releases it.
    task automatic doReset();
        redirect_i     = 1'b0;
        redirect_pc_i  = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        id_ready       = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_id_valid", 32'(id_valid), 32'd0);
        checkOutput("rst_req_addr", imem_req_addr, RESET_PC);
        checkOutput("rst_id_pc", id_pc, 32'd0);
        checkOutput("rst_id_pc_plus4", id_pc_plus4, 32'd4);
        checkOutput("rst_id_instr", id_instr, 32'd0);
        pend.delete();
        sb.delete();
        got_pcs.delete();
        accept_addrs.delete();
        epoch++;
        m_fetch_pc = RESET_PC;
        accepted   = 0;
        delivered  = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        epoch       = 0;
        cyc         = 0;
        lat_min     = 1;
        lat_max     = 1;
        reset       = 1'b1;
        @(negedge clk);

        // Sequential fetch with 1-cycle memory: delivery from cycle 2, no bubbles.
        doReset();
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("seq_count", 32'(delivered), 32'd10);
        checkOutput("seq_first_pc", got_pcs[0], 32'h100);

        // Back-pressure: ID stalled, exactly DEPTH requests go out.
        doReset();
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("bp_accepted", 32'(accepted), 32'd4);
        checkOutput("bp_req_valid", 32'(imem_req_valid), 32'd0);
        accept_addrs.delete();
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("bp_drain_n", 32'(got_pcs.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) checkOutput("bp_drain_pc", got_pcs[i], 32'h100 + 32'(4 * i));
        checkOutput("bp_resume_addr", accept_addrs[0], 32'h110);

        // Memory stall: request address held steady.
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_addr", imem_req_addr, m_fetch_pc);
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);

        // Redirect with two requests in flight on a 3-cycle memory.
        doReset();
        lat_min = 3;
        lat_max = 3;
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("rd_inflight", 32'(pend.size()), 32'd2);
        got_pcs.delete();
        applyStimulus(1'b1, 32'h2002, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("rd_got_n", 32'(got_pcs.size() >= 2), 32'd1);
        checkOutput("rd_first_pc", got_pcs[0], 32'h2000);
        checkOutput("rd_second_pc", got_pcs[1], 32'h2004);

        // Redirect in the same cycle as the only outstanding response.
        doReset();
        lat_min = 1;
        lat_max = 1;
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("co_pending", 32'(pend.size()), 32'd1);
        got_pcs.delete();
        applyStimulus(1'b1, 32'h3000, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("co_first_pc", got_pcs[0], 32'h3000);
        checkOutput("co_second_pc", got_pcs[1], 32'h3004);

        // Full queue, then asynchronous reset mid-stream.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput("full_id_valid", 32'(id_valid), 32'd1);
        checkOutput("full_count", 32'(sb.size()), 32'd4);
        doReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("ar_first_addr", accept_addrs[0], RESET_PC);
        checkOutput("ar_first_pc", got_pcs[0], RESET_PC);

        // Random traffic: variable latency, stalls and occasional redirects.
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage with its own PC register, a decoupled request/response interface to instruction memory, and a DEPTH-entry fetch queue that feeds the IF/ID boundary through a valid/ready handshake. It supports redirects (branch/jump/trap) that flush the queue and discard responses already in flight. It sits between the PC-redirect logic in EX and the ID stage, and it supports multi-cycle and back-pressured memories.

## Interface
- XLEN, 32, address/PC width
- DEPTH, 4, fetch-queue entries; power of two, ≥ 2; also bounds outstanding requests
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- redirect_i  in  1  flush and restart fetch at redirect_pc_i
- redirect_pc_i  in  XLEN  new fetch PC; bits [1:0] ignored (forced 0)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address
- imem_rsp_valid  in  1  instruction word returned (in order)
- imem_rsp_data  in  32  instruction word
- id_valid  out  1  queue head valid toward ID
- id_ready  in  1  ID consumes head
- id_pc  out  XLEN  PC of head instruction
- id_pc_plus4  out  XLEN  id_pc + 4, wraps modulo 2^XLEN
- id_instr  out  32  head instruction

## Operation
- State: fetch_pc, rsp_pc, FIFO (DEPTH × {pc, instr}), count, outstanding (0..DEPTH), drop_cnt (0..DEPTH).
- Request: imem_req_valid = !redirect_i && (count + outstanding < DEPTH); imem_req_addr = fetch_pc. On accept: fetch_pc += 4 and outstanding += 1.
- Response: outstanding -= 1.
  - If drop_cnt > 0: discard the response; drop_cnt -= 1.
  - Else: push {rsp_pc, imem_rsp_data}; rsp_pc += 4.
- Accept and response in the same cycle: outstanding is unchanged.
- Output: id_valid = (count != 0) && !redirect_i. The head fields come from the FIFO read pointer. id_pc_plus4 = head pc + 4. Pop on id_valid && id_ready.
- Overflow is impossible by construction (credit rule). A push and pop in the same cycle leave count unchanged.
- Redirect cycle:
  - No request is issued and no pop occurs.
  - The FIFO is emptied (count = 0, pointers reset).
  - fetch_pc and rsp_pc are set to {redirect_pc_i[XLEN-1:2], 2'b00}.
  - drop_cnt is set to outstanding − imem_rsp_valid (the outstanding value before the update). A response arriving in this cycle is always discarded.
  - outstanding is updated normally.
- Back-to-back redirects: the last one wins; drop accounting stays consistent.
- Arithmetic wraps modulo 2^XLEN. No misalignment or fault detection.

## Timing
- Reset (async assert, sync release):
  - fetch_pc = rsp_pc = RESET_PC; count = outstanding = drop_cnt = 0.
  - imem_req_valid = 0, imem_req_addr = RESET_PC.
  - id_valid = 0, id_pc = 0, id_pc_plus4 = 4, id_instr = 0 (storage cleared).
- First request is asserted in the first cycle after reset deassertion.
- Memory response latency is ≥ 1 cycle after acceptance and may vary; responses arrive strictly in request order.
- Latency: a response pushed in cycle n is visible on id_valid in cycle n+1. With 1-cycle memory: request at t0, response at t1, id_valid at t2.
- Throughput: with DEPTH ≥ 3, 1-cycle memory, and id_ready held high, one instruction per cycle is sustained.
- Redirect: the first request to the new PC is issued the cycle after redirect_i. id_valid stays low until the first non-dropped response has been pushed.
- Reset mid-operation clears all state immediately. Responses still arriving after release are not tracked, so the memory must be reset together with this block.

## Test plan
- Sequential fetch: RESET_PC = 0x100, 1-cycle memory, id_ready = 1 → id_pc sequence 0x100, 0x104, 0x108… starting at cycle 2 with no bubbles; id_pc_plus4 = id_pc + 4.
- Back-pressure: id_ready = 0 for 10 cycles, DEPTH = 4 → exactly 4 requests accepted, then imem_req_valid = 0. After release, 4 instructions drain in order and fetching resumes at 0x110.
- Memory stall: imem_req_ready = 0 for 5 cycles → imem_req_addr is held at the same PC and no duplicate entries appear.
- Redirect with in-flight requests: 3-cycle memory, 2 outstanding, redirect to 0x2002 → both old responses dropped; next id_pc = 0x2000, then 0x2004.
- Redirect coincident with a response: redirect_i and imem_rsp_valid in the same cycle, outstanding = 1 → drop_cnt = 0, response discarded, first delivered id_pc = redirect target.
- Async reset mid-stream: assert reset between clock edges with a full queue → id_valid and imem_req_valid fall immediately; after release, fetch restarts at RESET_PC.
